// File: rtl/unidade_controle_memoria_pkg.sv
// Shared definitions for the memory-game control unit: state encodings
// (also exported on db_estado) and the default play timeout.
package unidade_controle_memoria_pkg;

    localparam int unsigned TIMEOUT_CICLOS_PADRAO = 5000;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTOU    = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERROU      = 4'hE
    } estado_t;

endpackage

// File: rtl/unidade_controle_memoria_contador_timeout.sv
// Timeout counter for the wait-for-play state: synchronous clear and
// enable, asynchronous active-low reset, terminal flag at MODULO-1.
// Only instantiated when TIMEOUT_EN is defined.
module contador_timeout
    import unidade_controle_memoria_pkg::*;
#(
    parameter int unsigned MODULO = TIMEOUT_CICLOS_PADRAO,
    localparam int unsigned LARGURA = $clog2(MODULO)
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    logic [LARGURA-1:0] valor;

    // Cycle count register; clear has priority over counting
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor <= '0;
        end else if (zera) begin
            valor <= '0;
        end else if (conta) begin
            valor <= valor + LARGURA'(1);
        end
    end

    assign fim = (valor == LARGURA'(MODULO - 1));

endmodule

// File: rtl/unidade_controle_memoria.sv
// Moore control unit for the memory game datapath. Sequences the address
// and sequence counters and the play register, and judges each play.
// Optional play timeout is compiled in with the TIMEOUT_EN macro.
module unidade_controle_memoria
    import unidade_controle_memoria_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       jogadaIgualMemoria,
    input  logic       enderecoIgualSequencia,
    input  logic       fimS,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraS,
    output logic       contaS,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t estado;
    estado_t proximo;

    // A timeout shorter than two cycles cannot express a wait at all
    if (TIMEOUT_CICLOS < 2) begin : g_timeout_invalido
        $error("TIMEOUT_CICLOS must be at least 2");
    end

`ifdef TIMEOUT_EN
    logic fim_timer;

    contador_timeout #(
        .MODULO (TIMEOUT_CICLOS)
    ) u_contador_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (estado != ESPERA_JOGADA),
        .conta (estado == ESPERA_JOGADA),
        .fim   (fim_timer)
    );
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state logic; unused encodings fall back to inicial
    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:        proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     proximo = INICIO_RODADA;
            INICIO_RODADA:  proximo = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada) begin
                    proximo = REGISTRA;
`ifdef TIMEOUT_EN
                end else if (fim_timer) begin
                    proximo = FIM_TIMEOUT;
`endif
                end else begin
                    proximo = ESPERA_JOGADA;
                end
            end
            REGISTRA:       proximo = COMPARACAO;
            COMPARACAO: begin
                if (!jogadaIgualMemoria) begin
                    proximo = FIM_ERROU;
                end else if (!enderecoIgualSequencia) begin
                    proximo = PROXIMA_JOGADA;
                end else if (fimS) begin
                    proximo = FIM_ACERTOU;
                end else begin
                    proximo = PROXIMA_RODADA;
                end
            end
            PROXIMA_JOGADA: proximo = ESPERA_JOGADA;
            PROXIMA_RODADA: proximo = INICIO_RODADA;
            FIM_ACERTOU:    proximo = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:      proximo = iniciar ? PREPARACAO : FIM_ERROU;
            FIM_TIMEOUT:    proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:        proximo = INICIAL;
        endcase
    end

    // Moore output decode from the current state only
    always_comb begin
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraS     = 1'b0;
        contaS    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado)
            PREPARACAO: begin
                zeraE = 1'b1;
                zeraS = 1'b1;
                zeraR = 1'b1;
            end
            INICIO_RODADA:  zeraE = 1'b1;
            REGISTRA:       registraR = 1'b1;
            PROXIMA_JOGADA: contaE = 1'b1;
            PROXIMA_RODADA: contaS = 1'b1;
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
`ifdef TIMEOUT_EN
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                timeout = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_memoria.sv
// Self-checking bench for unidade_controle_memoria. Emulates the datapath
// counters from the control outputs and predicts every game from a model of
// round number and play position. Timeout scenarios run under TIMEOUT_EN.
module tb_unidade_controle_memoria;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       jogadaIgualMemoria;
    logic       enderecoIgualSequencia;
    logic       fimS;
    logic       zeraE, contaE, zeraS, contaS, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    logic [9:0] saidas;
    logic [3:0] addr_dp;
    logic [3:0] seq_dp;

    int checks = 0;
    int passed = 0;

    unidade_controle_memoria #(
        .TIMEOUT_CICLOS (8)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .iniciar                (iniciar),
        .jogada                 (jogada),
        .jogadaIgualMemoria     (jogadaIgualMemoria),
        .enderecoIgualSequencia (enderecoIgualSequencia),
        .fimS                   (fimS),
        .zeraE                  (zeraE),
        .contaE                 (contaE),
        .zeraS                  (zeraS),
        .contaS                 (contaS),
        .zeraR                  (zeraR),
        .registraR              (registraR),
        .pronto                 (pronto),
        .acertou                (acertou),
        .errou                  (errou),
        .timeout                (timeout),
        .db_estado              (db_estado)
    );

    always #5 clock = ~clock;

    assign saidas = {zeraE, contaE, zeraS, contaS, zeraR, registraR,
                     pronto, acertou, errou, timeout};

    // Datapath stand-in: address and sequence counters driven by the DUT
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_dp <= '0;
            seq_dp  <= '0;
        end else begin
            if (zeraE)       addr_dp <= '0;
            else if (contaE) addr_dp <= addr_dp + 4'd1;
            if (zeraS)       seq_dp  <= '0;
            else if (contaS) seq_dp  <= seq_dp + 4'd1;
        end
    end

    assign enderecoIgualSequencia = (addr_dp == seq_dp);
    assign fimS                   = (seq_dp == 4'd15);

    // Output table straight from the state descriptions:
    // {zeraE,contaE,zeraS,contaS,zeraR,registraR,pronto,acertou,errou,timeout}
    function automatic logic [9:0] saidas_esperadas(input logic [3:0] st);
        case (st)
            4'h1:    return 10'b1010100000;
            4'h2:    return 10'b1000000000;
            4'h4:    return 10'b0000010000;
            4'h6:    return 10'b0100000000;
            4'h7:    return 10'b0001000000;
            4'hA:    return 10'b0000001100;
            4'hE:    return 10'b0000001010;
            4'hD:    return 10'b0000001011;
            default: return 10'b0000000000;
        endcase
    endfunction

    task automatic test_reset();
        checks++;
        if ({db_estado, saidas} !== 14'h0)
            $display("[TB] FAIL reset_assert: got estado=%h saidas=%b, want estado=0 saidas=0", db_estado, saidas);
        else passed++;
        @(negedge clock);
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            checks++;
            if ({db_estado, saidas} !== 14'h0)
                $display("[TB] FAIL reset_idle[%0d]: got estado=%h saidas=%b, want estado=0 saidas=0", n, db_estado, saidas);
            else passed++;
        end
    endtask

    // Rows are {iniciar, jogada, expected state after the next edge}
    task automatic test_first_round();
        logic [5:0] linhas[$];
        jogadaIgualMemoria = 1'b1;
        linhas = '{6'b10_0001, 6'b00_0010, 6'b00_0011, 6'b01_0100,
                   6'b00_0101, 6'b00_0111, 6'b00_0010, 6'b00_0011};
        foreach (linhas[n]) begin
            iniciar = linhas[n][5];
            jogada  = linhas[n][4];
            @(negedge clock);
            checks++;
            if ({db_estado, saidas} !== {linhas[n][3:0], saidas_esperadas(linhas[n][3:0])})
                $display("[TB] FAIL first_round[%0d]: got estado=%h saidas=%b, want estado=%h saidas=%b",
                         n, db_estado, saidas, linhas[n][3:0], saidas_esperadas(linhas[n][3:0]));
            else passed++;
        end
        iniciar = 1'b0;
        jogada  = 1'b0;
    endtask

    task automatic test_round_two();
        logic [5:0] linhas[$];
        linhas = '{6'b01_0100, 6'b00_0101, 6'b00_0110, 6'b00_0011,
                   6'b01_0100, 6'b00_0101, 6'b00_0111, 6'b00_0010, 6'b00_0011};
        foreach (linhas[n]) begin
            iniciar = linhas[n][5];
            jogada  = linhas[n][4];
            @(negedge clock);
            checks++;
            if ({db_estado, saidas} !== {linhas[n][3:0], saidas_esperadas(linhas[n][3:0])})
                $display("[TB] FAIL round_two[%0d]: got estado=%h saidas=%b, want estado=%h saidas=%b",
                         n, db_estado, saidas, linhas[n][3:0], saidas_esperadas(linhas[n][3:0]));
            else passed++;
        end
        jogada = 1'b0;
        checks++;
        if ({addr_dp, seq_dp} !== {4'd0, 4'd2})
            $display("[TB] FAIL round_two_counters: got addr=%0d seq=%0d, want addr=0 seq=2", addr_dp, seq_dp);
        else passed++;
    endtask

    task automatic test_miss_and_restart();
        logic [5:0] linhas[$];
        jogadaIgualMemoria = 1'b0;
        linhas = '{6'b01_0100, 6'b00_0101, 6'b00_1110, 6'b01_1110,
                   6'b10_0001, 6'b00_0010, 6'b00_0011, 6'b10_0011, 6'b00_0011};
        foreach (linhas[n]) begin
            iniciar = linhas[n][5];
            jogada  = linhas[n][4];
            @(negedge clock);
            checks++;
            if ({db_estado, saidas} !== {linhas[n][3:0], saidas_esperadas(linhas[n][3:0])})
                $display("[TB] FAIL miss_restart[%0d]: got estado=%h saidas=%b, want estado=%h saidas=%b",
                         n, db_estado, saidas, linhas[n][3:0], saidas_esperadas(linhas[n][3:0]));
            else passed++;
        end
        iniciar = 1'b0;
        jogada  = 1'b0;
        jogadaIgualMemoria = 1'b1;
    endtask

    task automatic test_reset_mid_game();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({db_estado, saidas} !== 14'h0)
            $display("[TB] FAIL reset_mid_game: got estado=%h saidas=%b, want estado=0 saidas=0", db_estado, saidas);
        else passed++;
        @(negedge clock);
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            checks++;
            if (db_estado !== 4'h0)
                $display("[TB] FAIL reset_mid_idle[%0d]: got estado=%h, want estado=0", n, db_estado);
            else passed++;
        end
    endtask

    // Whole games: round k needs plays 0..k; a miss ends the game at once
    task automatic test_random_games(input int jogos, input int chance_erro);
        logic [5:0] linhas[$];
        int  rodada, posicao;
        bit  acerto, terminou;
        logic [3:0] veredito;
        for (int g = 0; g < jogos; g++) begin
            linhas = '{6'b10_0001, 6'b00_0010, 6'b00_0011};
            rodada   = 0;
            posicao  = 0;
            terminou = 1'b0;
            while (!terminou) begin
                foreach (linhas[n]) begin
                    iniciar = linhas[n][5];
                    jogada  = linhas[n][4];
                    @(negedge clock);
                    checks++;
                    if ({db_estado, saidas} !== {linhas[n][3:0], saidas_esperadas(linhas[n][3:0])})
                        $display("[TB] FAIL game%0d_r%0d_p%0d[%0d]: got estado=%h saidas=%b, want estado=%h saidas=%b",
                                 g, rodada, posicao, n, db_estado, saidas, linhas[n][3:0], saidas_esperadas(linhas[n][3:0]));
                    else passed++;
                end
                iniciar = 1'b0;
                jogada  = 1'b0;
                if (linhas[linhas.size()-1][3:0] != 4'h3) begin
                    terminou = 1'b1;
                end else begin
                    checks++;
                    if ({addr_dp, seq_dp} !== {4'(posicao), 4'(rodada)})
                        $display("[TB] FAIL game%0d_counters: got addr=%0d seq=%0d, want addr=%0d seq=%0d",
                                 g, addr_dp, seq_dp, posicao, rodada);
                    else passed++;
                    acerto = (chance_erro == 0) || ($urandom_range(0, chance_erro - 1) != 0);
                    jogadaIgualMemoria = acerto;
                    linhas = {};
                    repeat ($urandom_range(0, 2)) linhas.push_back(6'b00_0011);
                    linhas.push_back(6'b01_0100);
                    linhas.push_back(6'b00_0101);
                    if (!acerto)                veredito = 4'hE;
                    else if (posicao < rodada)  veredito = 4'h6;
                    else if (rodada == 15)      veredito = 4'hA;
                    else                        veredito = 4'h7;
                    linhas.push_back({2'b00, veredito});
                    if (veredito == 4'h6) begin
                        linhas.push_back(6'b00_0011);
                        posicao++;
                    end else if (veredito == 4'h7) begin
                        linhas.push_back(6'b00_0010);
                        linhas.push_back(6'b00_0011);
                        rodada++;
                        posicao = 0;
                    end
                end
            end
        end
        jogadaIgualMemoria = 1'b1;
    endtask

    task automatic test_final_hold();
        logic [5:0] linhas[$];
        linhas = '{6'b01_1010, 6'b00_1010, 6'b10_0001, 6'b00_0010, 6'b00_0011};
        foreach (linhas[n]) begin
            iniciar = linhas[n][5];
            jogada  = linhas[n][4];
            @(negedge clock);
            checks++;
            if ({db_estado, saidas} !== {linhas[n][3:0], saidas_esperadas(linhas[n][3:0])})
                $display("[TB] FAIL final_hold[%0d]: got estado=%h saidas=%b, want estado=%h saidas=%b",
                         n, db_estado, saidas, linhas[n][3:0], saidas_esperadas(linhas[n][3:0]));
            else passed++;
        end
        iniciar = 1'b0;
        jogada  = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] linhas[$];
        jogadaIgualMemoria = 1'b0;
        linhas = '{6'b10_0011, 6'b11_0100, 6'b10_0101, 6'b10_1110,
                   6'b10_0001, 6'b10_0010, 6'b10_0011};
        foreach (linhas[n]) begin
            iniciar = linhas[n][5];
            jogada  = linhas[n][4];
            @(negedge clock);
            checks++;
            if ({db_estado, saidas} !== {linhas[n][3:0], saidas_esperadas(linhas[n][3:0])})
                $display("[TB] FAIL back_to_back[%0d]: got estado=%h saidas=%b, want estado=%h saidas=%b",
                         n, db_estado, saidas, linhas[n][3:0], saidas_esperadas(linhas[n][3:0]));
            else passed++;
        end
        iniciar = 1'b0;
        jogada  = 1'b0;
        jogadaIgualMemoria = 1'b1;
    endtask

`ifdef TIMEOUT_EN
    task automatic test_timeout();
        logic [5:0] linhas[$];
        #2;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        linhas = '{6'b10_0001, 6'b00_0010, 6'b00_0011};
        repeat (7) linhas.push_back(6'b00_0011);
        linhas.push_back(6'b00_1101);
        linhas.push_back(6'b10_0001);
        linhas.push_back(6'b00_0010);
        linhas.push_back(6'b00_0011);
        repeat (7) linhas.push_back(6'b00_0011);
        linhas.push_back(6'b01_0100);
        linhas.push_back(6'b00_0101);
        linhas.push_back(6'b00_0111);
        foreach (linhas[n]) begin
            @(negedge clock);
            checks++;
            if ({db_estado, saidas} !== {linhas[n][3:0], saidas_esperadas(linhas[n][3:0])})
                $display("[TB] FAIL timeout[%0d]: got estado=%h saidas=%b, want estado=%h saidas=%b",
                         n, db_estado, saidas, linhas[n][3:0], saidas_esperadas(linhas[n][3:0]));
            else passed++;
            iniciar = (n + 1 < linhas.size()) ? linhas[n+1][5] : 1'b0;
            jogada  = (n + 1 < linhas.size()) ? linhas[n+1][4] : 1'b0;
        end
        iniciar = 1'b0;
        jogada  = 1'b0;
    endtask
`endif

    initial begin
        reset              = 1'b0;
        iniciar            = 1'b0;
        jogada             = 1'b0;
        jogadaIgualMemoria = 1'b1;
        #2;
        test_reset();
        test_first_round();
        test_round_two();
        test_miss_and_restart();
        test_reset_mid_game();
        test_random_games(3, 30);
        test_random_games(1, 0);
        test_final_hold();
        test_back_to_back();
`ifdef TIMEOUT_EN
        iniciar = 1'b1;
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
